leve1_csr_unit: RTL and testbench



---
 rtl/leve1_csr_unit.sv | 161 ++++++++++++++++
 tb/tb_leve1_csr_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leve1_csr_unit.sv
// rtl/leve1_csr_unit.sv - Zicsr execution unit: legality check, combined CSR read/modify/write, writeback or exception
module leve1_csr_unit #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [11:0]     i_req_csr,
    input  logic [4:0]      i_req_rs1,
    input  logic [XLEN-1:0] i_req_rs1_val,
    input  logic [4:0]      i_req_rd,
    input  logic [1:0]      i_priv,
    output logic [11:0]     o_csr_ra,
    input  logic [XLEN-1:0] i_csr_rd,
    output logic [1:0]      o_csr_wcmd,
    output logic [11:0]     o_csr_wa,
    output logic [XLEN-1:0] o_csr_wd,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_exc_valid,
    output logic [XLEN-1:0] o_exc_cause,
    output logic            o_retire
);

    localparam logic [1:0] CSR_NONE  = 2'd0;
    localparam logic [1:0] CSR_WRITE = 2'd1;
    localparam logic [1:0] CSR_SET   = 2'd2;
    localparam logic [1:0] CSR_CLEAR = 2'd3;

    // Illegal-instruction cause code
    localparam logic [XLEN-1:0] EXC_ILLEGAL = {{(XLEN-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [2:0]        r_funct3;
    logic [11:0]       r_csr;
    logic [4:0]        r_rs1;
    logic [XLEN-1:0]   r_rs1_val;
    logic [4:0]        r_rd;
    logic [1:0]        r_priv;

    logic              w_accept;
    logic [XLEN-1:0]   w_operand;
    logic              w_wr_intent;
    logic              w_illegal;
    logic [1:0]        w_cmd;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

    // Immediate forms zero-extend the 5-bit zimm carried in the rs1 field
    assign w_operand = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1} : r_rs1_val;

    // Plain writes always write; set/clear with rs1==0 are pure reads
    assign w_wr_intent = (r_funct3[1:0] == 2'b01) ||
                         ((r_funct3[1:0] != 2'b00) && (r_rs1 != 5'd0));

    // Unknown funct3, insufficient privilege, or a write to a read-only CSR
    assign w_illegal = (r_funct3[1:0] == 2'b00) ||
                       (r_priv < r_csr[9:8]) ||
                       (w_wr_intent && (r_csr[11:10] == 2'b11));

    // Map funct3 low bits onto the CSR file merge command
    always_comb begin
        w_cmd = CSR_NONE;
        case (r_funct3[1:0])
            2'b01:   w_cmd = CSR_WRITE;
            2'b10:   w_cmd = CSR_SET;
            2'b11:   w_cmd = CSR_CLEAR;
            default: w_cmd = CSR_NONE;
        endcase
    end

    // State register; reset drops any in-flight instruction
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the instruction fields on accept; held stable through ISSUE and RESP
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_funct3  <= 3'd0;
            r_csr     <= 12'd0;
            r_rs1     <= 5'd0;
            r_rs1_val <= '0;
            r_rd      <= 5'd0;
            r_priv    <= 2'd0;
        end else if (w_accept) begin
            r_funct3  <= i_req_funct3;
            r_csr     <= i_req_csr;
            r_rs1     <= i_req_rs1;
            r_rs1_val <= i_req_rs1_val;
            r_rd      <= i_req_rd;
            r_priv    <= i_priv;
        end
    end

    // Next-state and outputs decoded only from state and latched fields
    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        o_csr_ra     = 12'd0;
        o_csr_wcmd   = CSR_NONE;
        o_csr_wa     = 12'd0;
        o_csr_wd     = '0;
        o_wb_valid   = 1'b0;
        o_wb_rd      = 5'd0;
        o_wb_data    = '0;
        o_exc_valid  = 1'b0;
        o_exc_cause  = '0;
        o_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_csr_ra = r_csr;
                if (!w_illegal && w_wr_intent) begin
                    o_csr_wcmd = w_cmd;
                    o_csr_wa   = r_csr;
                    o_csr_wd   = w_operand;
                end
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (w_illegal) begin
                    o_exc_valid = 1'b1;
                    o_exc_cause = EXC_ILLEGAL;
                end else begin
                    o_retire = 1'b1;
                    if (r_rd != 5'd0) begin
                        o_wb_valid = 1'b1;
                        o_wb_rd    = r_rd;
                        o_wb_data  = i_csr_rd;
                    end
                end
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_leve1_csr_unit.sv
// tb/tb_leve1_csr_unit.sv - randomized and directed self-checking bench for leve1_csr_unit
module tb_leve1_csr_unit;

    logic        CLK;
    logic        RSTn;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_req_funct3;
    logic [11:0] i_req_csr;
    logic [4:0]  i_req_rs1;
    logic [63:0] i_req_rs1_val;
    logic [4:0]  i_req_rd;
    logic [1:0]  i_priv;
    logic [11:0] o_csr_ra;
    logic [63:0] i_csr_rd;
    logic [1:0]  o_csr_wcmd;
    logic [11:0] o_csr_wa;
    logic [63:0] o_csr_wd;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [63:0] o_wb_data;
    logic        o_exc_valid;
    logic [63:0] o_exc_cause;
    logic        o_retire;

    int n_tests = 0;
    int n_fail  = 0;

    leve1_csr_unit #(.XLEN(64)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_funct3 (i_req_funct3),
        .i_req_csr    (i_req_csr),
        .i_req_rs1    (i_req_rs1),
        .i_req_rs1_val(i_req_rs1_val),
        .i_req_rd     (i_req_rd),
        .i_priv       (i_priv),
        .o_csr_ra     (o_csr_ra),
        .i_csr_rd     (i_csr_rd),
        .o_csr_wcmd   (o_csr_wcmd),
        .o_csr_wa     (o_csr_wa),
        .o_csr_wd     (o_csr_wd),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_exc_valid  (o_exc_valid),
        .o_exc_cause  (o_exc_cause),
        .o_retire     (o_retire)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Power-on contents of every CSR, shared by the CSR file stand-in and the model
    function automatic logic [63:0] init_val(input logic [11:0] a);
        case (a)
            12'h340: return 64'h0000_0000_0000_1234;
            12'h001: return 64'h0000_0000_0000_001F;
            12'hC00: return 64'h0000_00AB_CDEF_0123;
            default: return {20'hA5A5A, a, ~a, 20'h0F0F0};
        endcase
    endfunction

    // CSR file stand-in: registered read, merge performed on write command
    bit [63:0] f_mem [4096];
    bit        f_wr  [4096];

    function automatic logic [63:0] f_read(input logic [11:0] a);
        return f_wr[a] ? f_mem[a] : init_val(a);
    endfunction

    initial i_csr_rd = 64'd0;
    always @(posedge CLK) begin
        i_csr_rd <= f_read(o_csr_ra);
        if (o_csr_wcmd != 2'd0) begin
            f_wr[o_csr_wa] <= 1'b1;
            case (o_csr_wcmd)
                2'd1:    f_mem[o_csr_wa] <= o_csr_wd;
                2'd2:    f_mem[o_csr_wa] <= f_read(o_csr_wa) | o_csr_wd;
                default: f_mem[o_csr_wa] <= f_read(o_csr_wa) & ~o_csr_wd;
            endcase
        end
    end

    // Behavioural model: instruction semantics computed from the Zicsr rules
    function automatic bit m_writes(input logic [2:0] f3, input logic [4:0] rs1);
        return (f3 == 3'd1) || (f3 == 3'd5) || (rs1 != 5'd0);
    endfunction

    function automatic bit m_legal(input logic [2:0] f3, input logic [11:0] csr,
                                   input logic [1:0] priv, input logic [4:0] rs1);
        bit known;
        bit priv_ok;
        bit read_only;
        known     = (f3 != 3'd0) && (f3 != 3'd4);
        priv_ok   = (int'(priv) >= int'(csr[9:8]));
        read_only = (csr[11:10] == 2'b11);
        return known && priv_ok && !(read_only && m_writes(f3, rs1));
    endfunction

    function automatic logic [1:0] m_kind(input logic [2:0] f3);
        if (f3 == 3'd1 || f3 == 3'd5) return 2'd1;
        if (f3 == 3'd2 || f3 == 3'd6) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [63:0] m_operand(input logic [2:0] f3, input logic [4:0] rs1,
                                              input logic [63:0] val);
        return (f3 >= 3'd5) ? {59'd0, rs1} : val;
    endfunction

    function automatic logic [63:0] m_merge(input logic [1:0] kind, input logic [63:0] old,
                                            input logic [63:0] op);
        if (kind == 2'd1) return op;
        if (kind == 2'd2) return old | op;
        return old & ~op;
    endfunction

    int          m_phase = 0;   // cycles since accept: 0 idle, 1 issue, 2 response
    logic [2:0]  m_f3    = 3'd0;
    logic [11:0] m_csr   = 12'd0;
    logic [4:0]  m_rs1   = 5'd0;
    logic [63:0] m_val   = 64'd0;
    logic [4:0]  m_rd    = 5'd0;
    logic [1:0]  m_priv  = 2'd0;
    logic [63:0] m_old   = 64'd0;
    bit [63:0]   sh_mem [4096];
    bit          sh_wr  [4096];

    function automatic logic [63:0] sh_read(input logic [11:0] a);
        return sh_wr[a] ? sh_mem[a] : init_val(a);
    endfunction

    // Model timeline: the CSR commits at the edge ending the issue cycle
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (i_req_valid) begin
                m_f3    <= i_req_funct3;
                m_csr   <= i_req_csr;
                m_rs1   <= i_req_rs1;
                m_val   <= i_req_rs1_val;
                m_rd    <= i_req_rd;
                m_priv  <= i_priv;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_old <= sh_read(m_csr);
            if (m_legal(m_f3, m_csr, m_priv, m_rs1) && m_writes(m_f3, m_rs1)) begin
                sh_wr[m_csr]  <= 1'b1;
                sh_mem[m_csr] <= m_merge(m_kind(m_f3), sh_read(m_csr), m_operand(m_f3, m_rs1, m_val));
            end
            m_phase <= 2;
        end else begin
            m_phase <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit lg;
        bit wr;
        lg = m_legal(m_f3, m_csr, m_priv, m_rs1);
        wr = m_writes(m_f3, m_rs1);
        chk("ready", {63'd0, o_req_ready}, {63'd0, m_phase == 0});
        if (m_phase == 1) begin
            chk("csr_ra", {52'd0, o_csr_ra}, {52'd0, m_csr});
            if (lg && wr) begin
                chk("csr_wcmd", {62'd0, o_csr_wcmd}, {62'd0, m_kind(m_f3)});
                chk("csr_wa", {52'd0, o_csr_wa}, {52'd0, m_csr});
                chk("csr_wd", o_csr_wd, m_operand(m_f3, m_rs1, m_val));
            end else begin
                chk("csr_wcmd_none", {62'd0, o_csr_wcmd}, 64'd0);
            end
        end else begin
            chk("idle_csr_ra", {52'd0, o_csr_ra}, 64'd0);
            chk("idle_csr_wcmd", {62'd0, o_csr_wcmd}, 64'd0);
            chk("idle_csr_wa", {52'd0, o_csr_wa}, 64'd0);
            chk("idle_csr_wd", o_csr_wd, 64'd0);
        end
        if (m_phase == 2) begin
            if (lg) begin
                chk("retire", {63'd0, o_retire}, 64'd1);
                chk("exc_valid", {63'd0, o_exc_valid}, 64'd0);
                chk("exc_cause", o_exc_cause, 64'd0);
                chk("wb_valid", {63'd0, o_wb_valid}, {63'd0, m_rd != 5'd0});
                if (m_rd != 5'd0) begin
                    chk("wb_rd", {59'd0, o_wb_rd}, {59'd0, m_rd});
                    chk("wb_data", o_wb_data, m_old);
                end
            end else begin
                chk("exc_valid", {63'd0, o_exc_valid}, 64'd1);
                chk("exc_cause", o_exc_cause, 64'd2);
                chk("wb_valid", {63'd0, o_wb_valid}, 64'd0);
                chk("retire", {63'd0, o_retire}, 64'd0);
            end
        end else begin
            chk("quiet_wb_valid", {63'd0, o_wb_valid}, 64'd0);
            chk("quiet_wb_rd", {59'd0, o_wb_rd}, 64'd0);
            chk("quiet_wb_data", o_wb_data, 64'd0);
            chk("quiet_exc_valid", {63'd0, o_exc_valid}, 64'd0);
            chk("quiet_exc_cause", o_exc_cause, 64'd0);
            chk("quiet_retire", {63'd0, o_retire}, 64'd0);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model
    task automatic tick();
        @(negedge CLK);
        check_model();
    endtask

    // Present one request for a single edge; returns in the issue cycle
    task automatic send(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1,
                        input logic [63:0] val, input logic [4:0] rd, input logic [1:0] priv);
        i_req_valid   = 1'b1;
        i_req_funct3  = f3;
        i_req_csr     = csr;
        i_req_rs1     = rs1;
        i_req_rs1_val = val;
        i_req_rd      = rd;
        i_priv        = priv;
        tick();
        i_req_valid   = 1'b0;
    endtask

    logic [11:0] pool [4];
    logic [8:0]  acc_mask;

    initial begin
        pool[0] = 12'h340; pool[1] = 12'h001; pool[2] = 12'h100; pool[3] = 12'hC00;
        RSTn = 1'b0;
        i_req_valid = 1'b0; i_req_funct3 = 3'd0; i_req_csr = 12'd0; i_req_rs1 = 5'd0;
        i_req_rs1_val = 64'd0; i_req_rd = 5'd0; i_priv = 2'd0;
        tick();
        tick();
        chk("rst_ready", {63'd0, o_req_ready}, 64'd1);
        chk("rst_wcmd", {62'd0, o_csr_wcmd}, 64'd0);
        chk("rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        chk("rst_exc_valid", {63'd0, o_exc_valid}, 64'd0);
        chk("rst_retire", {63'd0, o_retire}, 64'd0);
        RSTn = 1'b1;
        tick();

        // CSRRW mscratch, then read it back
        send(3'b001, 12'h340, 5'd1, 64'hDEAD_BEEF, 5'd5, 2'd3);
        chk("t1_wcmd", {62'd0, o_csr_wcmd}, 64'd1);
        chk("t1_wa", {52'd0, o_csr_wa}, 64'h340);
        chk("t1_wd", o_csr_wd, 64'hDEAD_BEEF);
        tick();
        chk("t1_wb_valid", {63'd0, o_wb_valid}, 64'd1);
        chk("t1_wb_rd", {59'd0, o_wb_rd}, 64'd5);
        chk("t1_wb_data", o_wb_data, 64'h1234);
        chk("t1_retire", {63'd0, o_retire}, 64'd1);
        tick();
        send(3'b010, 12'h340, 5'd0, 64'hFFFF_0000_FFFF_0000, 5'd6, 2'd3);
        tick();
        chk("t1b_wb_data", o_wb_data, 64'hDEAD_BEEF);
        tick();

        // CSRRS read of the cycle counter from user mode
        send(3'b010, 12'hC00, 5'd0, 64'h55, 5'd7, 2'd0);
        chk("t2_wcmd", {62'd0, o_csr_wcmd}, 64'd0);
        tick();
        chk("t2_wb_data", o_wb_data, 64'h0000_00AB_CDEF_0123);
        chk("t2_exc_valid", {63'd0, o_exc_valid}, 64'd0);
        tick();

        // CSRRWI to a read-only CSR
        send(3'b101, 12'hC00, 5'd1, 64'd0, 5'd8, 2'd3);
        chk("t3_wcmd", {62'd0, o_csr_wcmd}, 64'd0);
        tick();
        chk("t3_exc_valid", {63'd0, o_exc_valid}, 64'd1);
        chk("t3_exc_cause", o_exc_cause, 64'd2);
        chk("t3_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        chk("t3_retire", {63'd0, o_retire}, 64'd0);
        tick();

        // Privilege checks from supervisor mode
        send(3'b010, 12'h300, 5'd0, 64'd0, 5'd9, 2'd1);
        tick();
        chk("t4_m_csr_exc", {63'd0, o_exc_valid}, 64'd1);
        tick();
        send(3'b010, 12'h100, 5'd0, 64'd0, 5'd9, 2'd1);
        tick();
        chk("t4_s_csr_wb", {63'd0, o_wb_valid}, 64'd1);
        tick();

        // CSRRCI on fflags with rd=0
        send(3'b111, 12'h001, 5'd3, 64'd0, 5'd0, 2'd3);
        chk("t5_wcmd", {62'd0, o_csr_wcmd}, 64'd3);
        chk("t5_wd", o_csr_wd, 64'h3);
        tick();
        chk("t5_wb_valid", {63'd0, o_wb_valid}, 64'd0);
        chk("t5_retire", {63'd0, o_retire}, 64'd1);
        tick();
        send(3'b010, 12'h001, 5'd0, 64'd0, 5'd1, 2'd3);
        tick();
        chk("t5_fflags", o_wb_data, 64'h1C);
        tick();

        // Reset asserted during ISSUE drops the write and the response
        send(3'b001, 12'h340, 5'd2, 64'h5555, 5'd4, 2'd3);
        chk("t6_wcmd_pre", {62'd0, o_csr_wcmd}, 64'd1);
        RSTn = 1'b0;
        #1;
        chk("t6_ready", {63'd0, o_req_ready}, 64'd1);
        chk("t6_ra", {52'd0, o_csr_ra}, 64'd0);
        chk("t6_wcmd", {62'd0, o_csr_wcmd}, 64'd0);
        chk("t6_wa", {52'd0, o_csr_wa}, 64'd0);
        chk("t6_wd", o_csr_wd, 64'd0);
        tick();
        RSTn = 1'b1;
        tick();
        chk("t6_no_retire", {63'd0, o_retire}, 64'd0);
        chk("t6_no_wb", {63'd0, o_wb_valid}, 64'd0);
        send(3'b010, 12'h340, 5'd0, 64'd0, 5'd9, 2'd3);
        tick();
        chk("t6_after_wb", {63'd0, o_wb_valid}, 64'd1);
        chk("t6_after_data", o_wb_data, 64'hDEAD_BEEF);
        tick();

        // REQ_VALID held high for 9 edges
        acc_mask = 9'd0;
        i_req_valid = 1'b1; i_req_funct3 = 3'b010; i_req_csr = 12'h340;
        i_req_rs1 = 5'd0; i_req_rd = 5'd3; i_priv = 2'd3;
        for (int i = 0; i < 9; i++) begin
            acc_mask[i] = o_req_ready;
            tick();
        end
        i_req_valid = 1'b0;
        chk("b2b_accepts", {55'd0, acc_mask}, 64'b001_001_001);
        tick();
        tick();

        // Randomized traffic; inputs also change while the unit is busy
        for (int n = 0; n < 500; n++) begin
            i_req_valid   = ($urandom_range(0, 9) < 6);
            i_req_funct3  = 3'($urandom_range(0, 7));
            i_req_csr     = ($urandom_range(0, 2) == 0) ? 12'($urandom) : pool[$urandom_range(0, 3)];
            i_req_rs1     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            i_req_rs1_val = {$urandom, $urandom};
            i_req_rd      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            i_priv        = 2'($urandom);
            tick();
        end
        i_req_valid = 1'b0;
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
